// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired ALU control sequencer:
// sequencer states, supported opcodes, instruction-register field
// positions and opcode classification helpers.
package cpu_ctrl_pkg;

    // Sequencer states: IDLE plus the T0..T6 instruction steps
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        T6   = 3'd7
    } state_e;

    localparam int OP_BITS = 5;
    localparam int IDX_W   = 4;

    // Instruction register field positions
    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    typedef logic [OP_BITS-1:0] opcode_t;

    // Supported register-register opcodes
    localparam opcode_t OP_ADD = 5'b00011;
    localparam opcode_t OP_SUB = 5'b00100;
    localparam opcode_t OP_AND = 5'b00101;
    localparam opcode_t OP_OR  = 5'b00110;
    localparam opcode_t OP_SHR = 5'b00111;
    localparam opcode_t OP_SHL = 5'b01001;
    localparam opcode_t OP_MUL = 5'b01111;
    localparam opcode_t OP_DIV = 5'b10000;

    // True for every opcode this sequencer knows how to execute
    function automatic logic is_legal_op(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_MUL, OP_DIV: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // MUL and DIV produce a 64-bit result and need the extra HI/LO step
    function automatic logic is_muldiv(input opcode_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Bundle of run-control, memory handshake, instruction and datapath
// control signals between the sequencer (master) and the datapath (slave).
interface alu_ctrl_seq_if #(
    parameter int NUM_REGS = 16,
    parameter int OP_W     = 5
);
    logic                Start;
    logic                Mem_ready;
    logic [31:0]         IR;

    logic                PCout;
    logic                Zlowout;
    logic                Zhighout;
    logic                MDRout;
    logic                PCin;
    logic                MARin;
    logic                MDRin;
    logic                IRin;
    logic                Yin;
    logic                Zin;
    logic                HIin;
    logic                LOin;
    logic                IncPC;
    logic                Read;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    logic [OP_W-1:0]     Alu_op;
    logic                Busy;
    logic                Done;
    logic                Illegal;
    logic                Mem_err;

    modport master (
        input  Start, Mem_ready, IR,
        output PCout, Zlowout, Zhighout, MDRout,
        output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, Rin, Rout, Alu_op,
        output Busy, Done, Illegal, Mem_err
    );

    modport slave (
        output Start, Mem_ready, IR,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, Rin, Rout, Alu_op,
        input  Busy, Done, Illegal, Mem_err
    );

endinterface

// File: rtl/reg_sel_decode.sv
// Turns a register index plus enable into a one-hot register select.
module reg_sel_decode #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic [IDX_W-1:0]    idx_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] sel_o
);

    // One bit set at the indexed register when enabled, otherwise all zero
    always_comb begin
        sel_o = '0;
        if (en_i) begin
            sel_o = NUM_REGS'(1) << idx_i;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Hardwired control sequencer: steps the datapath through fetch
// (T0..T2), decode/operand (T3, T4) and writeback (T5, T6 for MUL/DIV).
module alu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int OP_W         = OP_BITS,
    parameter int MEM_WAIT_MAX = 8
) (
    input  logic           Clock,
    input  logic           Clear_n,
    alu_ctrl_seq_if.master bus
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
    logic              illegal_q, illegal_d;
    logic              memErr_q, memErr_d;

    opcode_t           opcode;
    logic [IDX_W-1:0]  ra, rb, rc;
    logic              legalOp;
    logic              mulDiv;
    logic              firstT1;
    logic              waitDone;
    logic [IDX_W-1:0]  routIdx;
    logic              routEn;
    logic              rinEn;
    logic              unusedIrLow;

    assign opcode      = bus.IR[IR_OP_MSB:IR_OP_LSB];
    assign ra          = bus.IR[IR_RA_MSB:IR_RA_LSB];
    assign rb          = bus.IR[IR_RB_MSB:IR_RB_LSB];
    assign rc          = bus.IR[IR_RC_MSB:IR_RC_LSB];
    assign unusedIrLow = ^bus.IR[IR_RC_LSB-1:0];

    assign legalOp  = is_legal_op(opcode);
    assign mulDiv   = is_muldiv(opcode);
    assign firstT1  = (waitCnt_q == '0);
    assign waitDone = (waitCnt_q == CNT_W'(MEM_WAIT_MAX - 1));

    // State, wait counter and sticky error flags; reset returns to IDLE at once
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            illegal_q <= 1'b0;
            memErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            illegal_q <= illegal_d;
            memErr_q  <= memErr_d;
        end
    end

    // Next state: one step per clock except while T1 waits for memory
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        illegal_d = illegal_q;
        memErr_d  = memErr_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d   = T0;
                    illegal_d = 1'b0;
                    memErr_d  = 1'b0;
                end
            end
            T0: begin
                state_d   = T1;
                waitCnt_d = '0;
            end
            T1: begin
                if (bus.Mem_ready) begin
                    state_d = T2;
                end else if (waitDone) begin
                    state_d  = IDLE;
                    memErr_d = 1'b1;
                end else if (waitCnt_q != CNT_W'(MEM_WAIT_MAX)) begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            T2: state_d = T3;
            T3: begin
                if (legalOp) begin
                    state_d = T4;
                end else begin
                    state_d   = IDLE;
                    illegal_d = 1'b1;
                end
            end
            T4: state_d = T5;
            T5: state_d = mulDiv ? T6 : IDLE;
            T6: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore control decode from the registered state and IR fields
    always_comb begin
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.PCin     = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.Alu_op   = '0;
        bus.Done     = 1'b0;
        case (state_q)
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = firstT1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                bus.Yin = legalOp;
            end
            T4: begin
                bus.Alu_op = OP_W'(opcode);
                bus.Zin    = 1'b1;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                bus.LOin    = mulDiv;
                bus.Done    = !mulDiv;
            end
            T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.Done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.Busy    = (state_q != IDLE);
    assign bus.Illegal = illegal_q;
    assign bus.Mem_err = memErr_q;

    assign routIdx = (state_q == T3) ? rb : rc;
    assign routEn  = ((state_q == T3) && legalOp) || (state_q == T4);
    assign rinEn   = (state_q == T5) && !mulDiv;

    reg_sel_decode #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_rout_dec (
        .idx_i (routIdx),
        .en_i  (routEn),
        .sel_o (bus.Rout)
    );

    reg_sel_decode #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_rin_dec (
        .idx_i (ra),
        .en_i  (rinEn),
        .sel_o (bus.Rin)
    );

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: every step drives inputs on the falling
// edge and compares all outputs against hand-written expected values.
module tb_alu_ctrl_seq;

    logic Clock = 1'b0;
    logic Clear_n;

    alu_ctrl_seq_if #(.NUM_REGS(16), .OP_W(5)) bus ();

    alu_ctrl_seq #(
        .NUM_REGS     (16),
        .OP_W         (5),
        .MEM_WAIT_MAX (8)
    ) dut (
        .Clock   (Clock),
        .Clear_n (Clear_n),
        .bus     (bus)
    );

    // 10-unit free-running clock
    always #5 Clock = ~Clock;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    localparam logic [15:0] C_PCOUT  = 16'h8000;
    localparam logic [15:0] C_ZLOW   = 16'h4000;
    localparam logic [15:0] C_ZHIGH  = 16'h2000;
    localparam logic [15:0] C_MDROUT = 16'h1000;
    localparam logic [15:0] C_PCIN   = 16'h0800;
    localparam logic [15:0] C_MARIN  = 16'h0400;
    localparam logic [15:0] C_MDRIN  = 16'h0200;
    localparam logic [15:0] C_IRIN   = 16'h0100;
    localparam logic [15:0] C_YIN    = 16'h0080;
    localparam logic [15:0] C_ZIN    = 16'h0040;
    localparam logic [15:0] C_HIIN   = 16'h0020;
    localparam logic [15:0] C_LOIN   = 16'h0010;
    localparam logic [15:0] C_INCPC  = 16'h0008;
    localparam logic [15:0] C_READ   = 16'h0004;
    localparam logic [15:0] C_BUSY   = 16'h0002;
    localparam logic [15:0] C_DONE   = 16'h0001;

    localparam logic [15:0] S_IDLE = 16'h0000;
    localparam logic [15:0] S_T0   = C_PCOUT | C_MARIN | C_INCPC | C_ZIN | C_BUSY;
    localparam logic [15:0] S_T1F  = C_ZLOW | C_PCIN | C_READ | C_MDRIN | C_BUSY;
    localparam logic [15:0] S_T1W  = C_ZLOW | C_READ | C_MDRIN | C_BUSY;
    localparam logic [15:0] S_T2   = C_MDROUT | C_IRIN | C_BUSY;
    localparam logic [15:0] S_T3   = C_YIN | C_BUSY;
    localparam logic [15:0] S_T3X  = C_BUSY;
    localparam logic [15:0] S_T4   = C_ZIN | C_BUSY;
    localparam logic [15:0] S_T5A  = C_ZLOW | C_BUSY | C_DONE;
    localparam logic [15:0] S_T5M  = C_ZLOW | C_LOIN | C_BUSY;
    localparam logic [15:0] S_T6   = C_ZHIGH | C_HIIN | C_BUSY | C_DONE;

    // AND R1 = R2 & R3
    localparam logic [31:0] IR_AND = 32'h2891_8000;
    // DIV with Ra=1, Rb=6, Rc=7
    localparam logic [31:0] IR_DIV = 32'h80B3_8000;
    // ADD R0 = R0 + R0
    localparam logic [31:0] IR_ADD0 = 32'h1800_0000;
    // unsupported opcode 11111 with Ra=1, Rb=2, Rc=3
    localparam logic [31:0] IR_ILL = 32'hF891_8000;

    function automatic logic [15:0] ctrlVec();
        return {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout,
                bus.PCin, bus.MARin, bus.MDRin, bus.IRin,
                bus.Yin, bus.Zin, bus.HIin, bus.LOin,
                bus.IncPC, bus.Read, bus.Busy, bus.Done};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStep(input string tag, input logic [15:0] expCtrl,
                             input logic [15:0] expRin, input logic [15:0] expRout,
                             input logic [4:0] expOp, input logic expIll,
                             input logic expMemErr);
        checkOutput({tag, " ctrl"},   32'(ctrlVec()),   32'(expCtrl));
        checkOutput({tag, " Rin"},    32'(bus.Rin),     32'(expRin));
        checkOutput({tag, " Rout"},   32'(bus.Rout),    32'(expRout));
        checkOutput({tag, " Alu_op"}, 32'(bus.Alu_op),  32'(expOp));
        checkOutput({tag, " flags"},  32'({bus.Illegal, bus.Mem_err}),
                    32'({expIll, expMemErr}));
    endtask

    task automatic applyStimulus(input logic start, input logic memReady,
                                 input logic [31:0] ir);
        bus.Start     = start;
        bus.Mem_ready = memReady;
        bus.IR        = ir;
        @(negedge Clock);
    endtask

    // Linear sequence of directed scenarios
    initial begin
        Clear_n       = 1'b0;
        bus.Start     = 1'b0;
        bus.Mem_ready = 1'b0;
        bus.IR        = 32'h0;
        @(negedge Clock);
        checkStep("reset", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        Clear_n = 1'b1;
        @(negedge Clock);
        checkStep("idle", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        $display("[TB] AND R1,R2,R3 with memory always ready");
        applyStimulus(1'b1, 1'b1, IR_AND);
        checkStep("and T0", S_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("and T1", S_T1F, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("and T2", S_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("and T3", S_T3, 16'h0, 16'h0004, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("and T4", S_T4, 16'h0, 16'h0008, 5'b00101, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("and T5 cycle6", S_T5A, 16'h0002, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("and end", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        $display("[TB] DIV R1,R6,R7");
        applyStimulus(1'b1, 1'b1, IR_DIV);
        checkStep("div T0", S_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_DIV);
        checkStep("div T1", S_T1F, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_DIV);
        checkStep("div T2", S_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_DIV);
        checkStep("div T3", S_T3, 16'h0, 16'h0040, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_DIV);
        checkStep("div T4", S_T4, 16'h0, 16'h0080, 5'b10000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_DIV);
        checkStep("div T5", S_T5M, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_DIV);
        checkStep("div T6", S_T6, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_DIV);
        checkStep("div end", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        $display("[TB] ADD R0,R0,R0 with three memory wait cycles");
        applyStimulus(1'b1, 1'b0, IR_ADD0);
        checkStep("wait T0", S_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, IR_ADD0);
        checkStep("wait T1 #1", S_T1F, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, IR_ADD0);
        checkStep("wait T1 #2", S_T1W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, IR_ADD0);
        checkStep("wait T1 #3", S_T1W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, IR_ADD0);
        checkStep("wait T1 #4", S_T1W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_ADD0);
        checkStep("wait T2", S_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_ADD0);
        checkStep("wait T3", S_T3, 16'h0, 16'h0001, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_ADD0);
        checkStep("wait T4", S_T4, 16'h0, 16'h0001, 5'b00011, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_ADD0);
        checkStep("wait T5", S_T5A, 16'h0001, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_ADD0);
        checkStep("wait end", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        $display("[TB] memory never ready, expect timeout");
        applyStimulus(1'b1, 1'b0, IR_AND);
        checkStep("tmo T0", S_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, IR_AND);
        checkStep("tmo T1 #1", S_T1F, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, IR_AND);
            checkStep($sformatf("tmo T1 #%0d", i), S_T1W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, IR_AND);
        checkStep("tmo idle", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("tmo sticky", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1);

        $display("[TB] illegal opcode with Start held high");
        applyStimulus(1'b1, 1'b1, IR_ILL);
        checkStep("ill T0", S_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, IR_ILL);
        checkStep("ill T1", S_T1F, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, IR_ILL);
        checkStep("ill T2", S_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, IR_ILL);
        checkStep("ill T3", S_T3X, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, IR_ILL);
        checkStep("ill idle", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_ILL);
        checkStep("ill sticky", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);

        $display("[TB] asynchronous reset during T4");
        applyStimulus(1'b1, 1'b1, IR_AND);
        checkStep("rst T0", S_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        applyStimulus(1'b0, 1'b1, IR_AND);
        applyStimulus(1'b0, 1'b1, IR_AND);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("rst T4", S_T4, 16'h0, 16'h0008, 5'b00101, 1'b0, 1'b0);
        #2 Clear_n = 1'b0;
        #1 checkStep("rst async", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        #1 Clear_n = 1'b1;
        @(negedge Clock);
        checkStep("rst idle", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, IR_AND);
        checkStep("rerun T0", S_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("rerun T1", S_T1F, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("rerun T3", S_T3, 16'h0, 16'h0004, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("rerun T5", S_T5A, 16'h0002, 16'h0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, IR_AND);
        checkStep("rerun end", S_IDLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Hardwired control sequencer for the CPU datapath.
- Executes register-register ALU instructions, including MUL and DIV, by stepping through the datapath in states T0–T6.
- Drives the datapath's bus-source selects, register-load enables, memory read strobe and ALU opcode.
- Sits between the top-level run control and the datapath; replaces hand-driven control in benches.

Parameters:
- NUM_REGS, 16: general-purpose registers; width of Rin/Rout one-hot vectors.
- OP_W, 5: ALU opcode width (IR[31:27]).
- MEM_WAIT_MAX, 8: maximum cycles the block waits in T1 for Mem_ready.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Clear_n  in  1  reset, asynchronous, active-low.
- Start  in  1  begin one instruction; sampled only in IDLE.
- Mem_ready  in  1  memory read data valid on Mdatain this cycle.
- IR  in  32  datapath instruction register contents; valid from T3 onward.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus source selects.
- PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load enables.
- IncPC  out  1  ALU performs PC+1 this cycle.
- Read  out  1  memory read strobe.
- Rin  out  NUM_REGS  one-hot GPR load enable.
- Rout  out  NUM_REGS  one-hot GPR bus drive.
- Alu_op  out  OP_W  ALU opcode to datapath.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse in the final state of a legal instruction.
- Illegal  out  1  sticky; set on an unsupported opcode, cleared when the next Start is accepted.
- Mem_err  out  1  sticky; set on T1 timeout, cleared when the next Start is accepted.

Behaviour:
- Reset:
  - Clear_n low forces IDLE immediately, from any state, including mid-instruction.
  - All outputs go to 0: Rin=0, Rout=0, Alu_op=0, Illegal=0, Mem_err=0, wait counter=0.
- Output decode:
  - Moore outputs, decoded from the registered state (plus IR fields where noted). No other output is asserted in any state.
- States and actions (each state lasts one clock unless stated):
  - IDLE: all controls 0. Start=1 → T0.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
    - Holds in T1 while Mem_ready=0; Read stays high; PCin is asserted only on the first T1 cycle.
    - Mem_ready=1 → T2.
    - Wait counter reaches MEM_WAIT_MAX with Mem_ready still 0 → Mem_err=1, go to IDLE.
  - T2: MDRout, IRin.
  - T3: decode opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
    - Legal opcode: Rout[Rb]=1, Yin=1.
    - Illegal opcode: no controls asserted, Illegal=1, go to IDLE.
  - T4: Rout[Rc]=1, Alu_op=opcode, Zin=1.
  - T5, non-MUL/DIV: Zlowout, Rin[Ra]=1, Done=1 → IDLE.
  - T5, MUL/DIV: Zlowout, LOin → T6.
  - T6: Zhighout, HIin, Done=1 → IDLE.
- Latency: Start-accept edge to Done = 6 cycles (ALU op) or 7 cycles (MUL/DIV), plus any T1 wait cycles.
- Legal opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01001, MUL 01111, DIV 10000. Everything else is illegal.
- Alu_op is held at 0 outside T4.
- Start is ignored while Busy. The final state always returns to IDLE, so back-to-back instructions have a minimum 1-cycle IDLE gap.
- Wait counter: reset on entry to T1, saturating.
- Register indices: Ra=Rb=Rc is legal; the same one-hot bit is driven in the respective states. Register 0 is treated like any other.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (IDLE, T0–T6);
  - opcode localparams;
  - IR field bit positions;
  - function is_legal_op.
- One sub-module, reg_sel_decode: 4-bit index + enable → NUM_REGS one-hot. Instantiated for Rin and for Rout, with the Rout instance driven by a muxed Rb/Rc index.

Test Plan:
- AND: R2=0x12, R3=0x14, IR=0x28918000, Mem_ready tied high, Start pulse → states T0..T5, Rout=0x0004 in T3, Rout=0x0008 and Alu_op=00101 in T4, Rin=0x0002 with Done in T5; Done 6 cycles after the Start edge.
- DIV: IR opcode 10000, Ra=1, Rb=6, Rc=7 → T5 asserts LOin+Zlowout, T6 asserts HIin+Zhighout, Done in T6, Rin never asserted.
- Memory wait: Mem_ready low for 3 cycles in T1 → Read high for 4 cycles, PCin high only on the first; IRin asserted the cycle after Mem_ready.
- Timeout: Mem_ready held low → after MEM_WAIT_MAX cycles Mem_err=1, state IDLE, Done never pulses; next Start clears Mem_err.
- Illegal opcode 11111 → Illegal=1 at the end of T3, no Yin/Zin/Rin asserted, back to IDLE; Start ignored while Busy throughout.
- Reset: Clear_n pulsed low mid-T4 → outputs 0 immediately (asynchronously), state IDLE; a fresh Start runs normally.
